// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_pkg
//  Purpose  : Shared types and constants for the digital clock time keeper:
//             mode encodings, converter field-select codes and the minute /
//             second limit, plus a modulo-increment helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_SEC = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    SEL_SEC = 2'd0,
    SEL_MIN = 2'd1,
    SEL_HR  = 2'd2
  } sel_t;

  localparam logic [5:0] MIN_SEC_MAX = 6'd59;

  // Increment with wrap to zero once the last legal value is passed. Using
  // >= means a corrupted out-of-range value also falls back to zero.
  function automatic logic [5:0] wrap_inc(input logic [5:0] val,
                                          input logic [5:0] last_val);
    return (val >= last_val) ? 6'd0 : val + 6'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd
//  Purpose  : Combinational two-digit binary to BCD converter (0..99).
//             Inputs above 99 return 0xF in both digits.
//  Ports    : bin  [6:0] binary value
//             tens [3:0] BCD tens digit
//             unit [3:0] BCD units digit
//  Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] unit
);

  always_comb begin
    tens = 4'd0;
    unit = 4'd0;
    if (bin > 7'd99) begin
      tens = 4'hF;
      unit = 4'hF;
    end else begin
      // Largest k with bin >= 10*k gives the tens digit.
      for (int k = 1; k < 10; k++) begin
        if (bin >= 7'(k * 10)) begin
          tens = 4'(k);
        end
      end
      unit = 4'(bin - ({3'b000, tens} * 7'd10));
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : clock_tick_gen
//  Purpose  : Divides clk down to a one-cycle tick every TICK_DIV cycles.
//             The count advances only while en is high; clr holds it at 0.
//  Ports    : clk   system clock
//             rst_n synchronous active-low reset
//             en    count enable
//             clr   synchronous clear (dominates en)
//             tick  high on the cycle the count equals TICK_DIV-1
//  Revision : 1.0 - initial release
// ============================================================================
module clock_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  // Decoded from the count so the tick lands on the cycle count==LAST.
  assign tick = en && !clr && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/clock_time_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clock_time_ctrl
//  Purpose  : Time keeping and display conversion for the digital clock.
//             Holds hh:mm:ss binary counters advanced by a one-second tick,
//             runs the RUN/SET_HR/SET_MIN/SET_SEC set-mode FSM from two
//             button pulses, and time-shares one bin_to_bcd converter across
//             the three fields to refresh six registered BCD digits.
//  Ports    : clk, rst_n          clock, synchronous active-low reset
//             mode_btn, inc_btn   debounced single-cycle button pulses
//             mode[1:0]           current mode (0 RUN .. 3 SET_SEC)
//             sec_tick            one-cycle pulse per second advance
//             blink               blink enable for the field being set
//             hr/min/sec_tens,unit registered BCD digits
//             bcd_valid           pulse after each full three-field refresh
//  Revision : 1.0 - initial release
// ============================================================================
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int HOUR_MAX = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [1:0] mode,
  output logic       sec_tick,
  output logic       blink,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_unit,
  output logic [3:0] min_tens,
  output logic [3:0] min_unit,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_unit,
  output logic       bcd_valid
);

  localparam logic [5:0] HR_LAST    = 6'(HOUR_MAX - 1);
  localparam int         BLINK_HALF = ((TICK_DIV / 2) < 1) ? 1 : (TICK_DIV / 2);
  localparam int         BW         = $clog2(BLINK_HALF + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  mode_t         mode_q;
  sel_t          ptr;
  logic [5:0]    hr_bin;
  logic [5:0]    min_bin;
  logic [5:0]    sec_bin;
  logic [BW-1:0] blink_cnt;
  logic          run;
  logic          tick;
  logic [6:0]    conv_in;
  logic [3:0]    conv_tens;
  logic [3:0]    conv_unit;

  assign run      = (mode_q == MODE_RUN);
  assign mode     = mode_q;
  assign sec_tick = tick;

  // --------------------------------------------------------------------------
  // One-second divider: only counts in RUN and is held at zero otherwise, so
  // leaving set mode always gives a full second before the first tick.
  // --------------------------------------------------------------------------
  clock_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .clr   (!run),
    .tick  (tick)
  );

  // --------------------------------------------------------------------------
  // Mode FSM and time counters. A mode press wins over a simultaneous inc.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= MODE_RUN;
      hr_bin  <= 6'd0;
      min_bin <= 6'd0;
      sec_bin <= 6'd0;
    end else begin
      if (mode_btn) begin
        case (mode_q)
          MODE_RUN:     mode_q <= MODE_SET_HR;
          MODE_SET_HR:  mode_q <= MODE_SET_MIN;
          MODE_SET_MIN: mode_q <= MODE_SET_SEC;
          default:      mode_q <= MODE_RUN;
        endcase
      end

      if (tick) begin
        // Full carry chain resolves in one cycle.
        sec_bin <= wrap_inc(sec_bin, MIN_SEC_MAX);
        if (sec_bin == MIN_SEC_MAX) begin
          min_bin <= wrap_inc(min_bin, MIN_SEC_MAX);
          if (min_bin == MIN_SEC_MAX) begin
            hr_bin <= wrap_inc(hr_bin, HR_LAST);
          end
        end
      end else if (inc_btn && !mode_btn) begin
        // Set-mode increments touch only the selected field, no carry.
        case (mode_q)
          MODE_SET_HR:  hr_bin  <= wrap_inc(hr_bin, HR_LAST);
          MODE_SET_MIN: min_bin <= wrap_inc(min_bin, MIN_SEC_MAX);
          MODE_SET_SEC: sec_bin <= wrap_inc(sec_bin, MIN_SEC_MAX);
          default:      ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Blink generator. Entering set mode starts with the field visible; the
  // phase carries across set-mode steps and is forced off on return to RUN.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (run) begin
      blink     <= mode_btn;
      blink_cnt <= '0;
    end else if (mode_q == MODE_SET_SEC && mode_btn) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink     <= !blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Shared converter: the round-robin pointer picks one field per cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    conv_in = 7'd0;
    case (ptr)
      SEL_SEC: conv_in = {1'b0, sec_bin};
      SEL_MIN: conv_in = {1'b0, min_bin};
      SEL_HR:  conv_in = {1'b0, hr_bin};
      default: conv_in = 7'd0;
    endcase
  end

  bin_to_bcd u_bin_to_bcd (
    .bin  (conv_in),
    .tens (conv_tens),
    .unit (conv_unit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= SEL_SEC;
      bcd_valid <= 1'b0;
      hr_tens   <= 4'd0;
      hr_unit   <= 4'd0;
      min_tens  <= 4'd0;
      min_unit  <= 4'd0;
      sec_tens  <= 4'd0;
      sec_unit  <= 4'd0;
    end else begin
      // The hr slot is last, so the pulse after it marks a complete refresh.
      bcd_valid <= (ptr == SEL_HR);
      case (ptr)
        SEL_SEC: begin
          sec_tens <= conv_tens;
          sec_unit <= conv_unit;
          ptr      <= SEL_MIN;
        end
        SEL_MIN: begin
          min_tens <= conv_tens;
          min_unit <= conv_unit;
          ptr      <= SEL_HR;
        end
        SEL_HR: begin
          hr_tens  <= conv_tens;
          hr_unit  <= conv_unit;
          ptr      <= SEL_SEC;
        end
        default: ptr <= SEL_SEC;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_time_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_time_ctrl
//  Purpose  : Self-checking bench for clock_time_ctrl (TICK_DIV=4,
//             HOUR_MAX=24). A behavioural model tracks mode, divider, time
//             (as seconds of day), blink and refresh phase; expected display
//             words are queued when time settles and popped when the DUT has
//             had time to refresh them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_time_ctrl;

  localparam int TD   = 4;
  localparam int HM   = 24;
  localparam int HALF = 2;

  logic       clk;
  logic       rst_n;
  logic       mode_btn;
  logic       inc_btn;
  logic [1:0] mode;
  logic       sec_tick;
  logic       blink;
  logic [3:0] hr_tens, hr_unit, min_tens, min_unit, sec_tens, sec_unit;
  logic       bcd_valid;
  logic [23:0] digits;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_mode, m_div, m_h, m_m, m_s, m_blink, m_bcnt, m_ptr, m_valid;
  logic [23:0] exp_q[$];

  clock_time_ctrl #(
    .TICK_DIV (TD),
    .HOUR_MAX (HM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .mode      (mode),
    .sec_tick  (sec_tick),
    .blink     (blink),
    .hr_tens   (hr_tens),
    .hr_unit   (hr_unit),
    .min_tens  (min_tens),
    .min_unit  (min_unit),
    .sec_tens  (sec_tens),
    .sec_unit  (sec_unit),
    .bcd_valid (bcd_valid)
  );

  assign digits = {hr_tens, hr_unit, min_tens, min_unit, sec_tens, sec_unit};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pack(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_div = 0; m_h = 0; m_m = 0; m_s = 0;
    m_blink = 0; m_bcnt = 0; m_ptr = 0; m_valid = 0;
  endfunction

  // Advance one clock edge and update the model with the inputs the DUT saw.
  task automatic step();
    int  om;
    int  tot;
    bit  tk;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      om = m_mode;
      tk = (om == 0) && (m_div == TD - 1);
      if (mode_btn) m_mode = (om + 1) % 4;
      if (tk) begin
        tot = (m_h * 3600 + m_m * 60 + m_s + 1) % (HM * 3600);
        m_h = tot / 3600; m_m = (tot / 60) % 60; m_s = tot % 60;
      end else if (inc_btn && !mode_btn) begin
        case (om)
          1: m_h = (m_h + 1) % HM;
          2: m_m = (m_m + 1) % 60;
          3: m_s = (m_s + 1) % 60;
          default: ;
        endcase
      end
      m_div = (om == 0) ? (m_div + 1) % TD : 0;
      if (om == 0) begin
        m_blink = mode_btn ? 1 : 0; m_bcnt = 0;
      end else if (om == 3 && mode_btn) begin
        m_blink = 0; m_bcnt = 0;
      end else if (m_bcnt == HALF - 1) begin
        m_blink = 1 - m_blink; m_bcnt = 0;
      end else begin
        m_bcnt++;
      end
      m_valid = (m_ptr == 2) ? 1 : 0;
      m_ptr   = (m_ptr + 1) % 3;
    end
    #1;
  endtask

  task automatic press(input logic mb, input logic ib);
    mode_btn = mb; inc_btn = ib;
    step();
    mode_btn = 1'b0; inc_btn = 1'b0;
  endtask

  task automatic inc_to_hr(input int target);
    for (int k = 0; k < 70 && m_h != target; k++) press(1'b0, 1'b1);
  endtask
  task automatic inc_to_min(input int target);
    for (int k = 0; k < 70 && m_m != target; k++) press(1'b0, 1'b1);
  endtask
  task automatic inc_to_sec(input int target);
    for (int k = 0; k < 70 && m_s != target; k++) press(1'b0, 1'b1);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [23:0] e;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mode_btn = (i == 0); inc_btn = (i == 1);
      step();
      n_checks++;
      if ({mode, sec_tick, blink, bcd_valid} !== 5'b0 || digits !== 24'h0) begin
        n_fail++;
        $display("FAIL reset_state: mode=%0d tick=%b blink=%b valid=%b digits=%h, want all 0",
                 mode, sec_tick, blink, bcd_valid, digits);
      end
    end
    mode_btn = 1'b0; inc_btn = 1'b0; rst_n = 1'b1;
    exp_q.push_back(pack(0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bcd_valid !== (i == 2)) begin
        n_fail++;
        $display("FAIL reset_first_valid: cycle %0d bcd_valid=%b want %b", i + 1, bcd_valid, (i == 2));
      end
    end
    e = exp_q.pop_front();
    n_checks++;
    if (digits !== e) begin
      n_fail++;
      $display("FAIL reset_digits: got %h want %h", digits, e);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_set_hours();
    int m0, s0;
    logic [23:0] e;
    press(1'b1, 1'b0);
    n_checks++;
    if (mode !== 2'd1 || blink !== 1'b1) begin
      n_fail++;
      $display("FAIL sethr_enter: mode=%0d blink=%b want 1 1", mode, blink);
    end
    m0 = m_m; s0 = m_s;
    for (int k = 1; k <= 25; k++) begin
      press(1'b0, 1'b1);
      n_checks++;
      if (sec_tick !== 1'b0 || blink !== (((k / 2) % 2) == 0)) begin
        n_fail++;
        $display("FAIL sethr_blink: k=%0d tick=%b blink=%b want 0 %b",
                 k, sec_tick, blink, (((k / 2) % 2) == 0));
      end
    end
    exp_q.push_back(pack(1, m0, s0));
    repeat (6) step();
    e = exp_q.pop_front();
    n_checks++;
    if (digits !== e || mode !== 2'd1) begin
      n_fail++;
      $display("FAIL sethr_value: digits=%h mode=%0d want %h 1", digits, mode, e);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_rollover();
    logic [23:0] e;
    inc_to_hr(23);
    press(1'b1, 1'b0);
    inc_to_min(59);
    press(1'b1, 1'b0);
    inc_to_sec(59);
    exp_q.push_back(pack(23, 59, 59));
    press(1'b1, 1'b0);
    n_checks++;
    if (mode !== 2'd0 || blink !== 1'b0 || sec_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL roll_run: mode=%0d blink=%b tick=%b want 0 0 0", mode, blink, sec_tick);
    end
    for (int i = 2; i <= 4; i++) begin
      step();
      n_checks++;
      if (sec_tick !== (i == 4)) begin
        n_fail++;
        $display("FAIL roll_tick: cycle %0d sec_tick=%b want %b", i, sec_tick, (i == 4));
      end
    end
    e = exp_q.pop_front();
    n_checks++;
    if (digits !== e) begin
      n_fail++;
      $display("FAIL roll_pre: digits=%h want %h", digits, e);
    end
    exp_q.push_back(pack(0, 0, 0));
    step();
    repeat (3) step();
    e = exp_q.pop_front();
    n_checks++;
    if (digits !== e) begin
      n_fail++;
      $display("FAIL roll_post: digits=%h want %h", digits, e);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_simultaneous();
    logic [23:0] e;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    inc_to_min(7);
    press(1'b1, 1'b1);
    n_checks++;
    if (mode !== 2'd3) begin
      n_fail++;
      $display("FAIL simul_mode: mode=%0d want 3", mode);
    end
    exp_q.push_back(pack(m_h, 7, m_s));
    repeat (6) step();
    e = exp_q.pop_front();
    n_checks++;
    if (digits !== e) begin
      n_fail++;
      $display("FAIL simul_min: digits=%h want %h", digits, e);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_scheduler();
    int pulses;
    inc_to_sec(9);
    press(1'b1, 1'b0);
    repeat (3) step();
    n_checks++;
    if (sec_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL sched_tick: sec_tick=%b want 1", sec_tick);
    end
    step();
    repeat (3) step();
    n_checks++;
    if (sec_tens !== 4'd1 || sec_unit !== 4'd0) begin
      n_fail++;
      $display("FAIL sched_sec10: sec=%0d%0d want 10", sec_tens, sec_unit);
    end
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (bcd_valid === 1'b1) pulses++;
      n_checks++;
      if (bcd_valid !== 1'(m_valid)) begin
        n_fail++;
        $display("FAIL sched_valid: cycle %0d bcd_valid=%b want %0d", i, bcd_valid, m_valid);
      end
    end
    n_checks++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL sched_rate: %0d pulses in 9 cycles want 3", pulses);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_set();
    logic [23:0] e;
    press(1'b1, 1'b0);
    inc_to_hr(15);
    exp_q.push_back(pack(15, m_m, m_s));
    repeat (6) step();
    e = exp_q.pop_front();
    n_checks++;
    if (digits !== e || mode !== 2'd1) begin
      n_fail++;
      $display("FAIL midrst_pre: digits=%h mode=%0d want %h 1", digits, mode, e);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({mode, sec_tick, blink, bcd_valid} !== 5'b0 || digits !== 24'h0) begin
      n_fail++;
      $display("FAIL midrst_state: mode=%0d tick=%b blink=%b valid=%b digits=%h want all 0",
               mode, sec_tick, blink, bcd_valid, digits);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bcd_valid !== (i == 2) || digits !== 24'h0) begin
        n_fail++;
        $display("FAIL midrst_ptr: cycle %0d bcd_valid=%b digits=%h want %b 000000",
                 i + 1, bcd_valid, digits, (i == 2));
      end
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    model_reset();
    rst_n = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    test_reset();
    test_set_hours();
    test_rollover();
    test_simultaneous();
    test_scheduler();
    test_reset_mid_set();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
